// File: rtl/uart_tx_stream.sv
// uart_tx_stream: buffered 8N1 UART transmitter.
// Bytes written through iWR/iDATA are queued in a circular FIFO and sent
// LSB first on oTX (one start bit low, eight data bits, one stop bit high).
// When another byte is waiting at the end of a stop bit, the next frame
// starts on the following cycle, so frames leave back-to-back.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   iDATA      byte to queue
//   iWR        write strobe, one byte per cycle while high
//   iCLR_OVF   synchronous clear of oOVERFLOW
//   oTX        serial line, idle high, registered
//   oBUSY      high while a frame is on the line
//   oFULL      FIFO holds FIFO_DEPTH entries
//   oEMPTY     FIFO holds no entries
//   oLEVEL     current FIFO entry count
//   oOVERFLOW  sticky flag, set when a write is dropped because the FIFO is full
module uart_tx_stream #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    iDATA,
    input  logic                          iWR,
    input  logic                          iCLR_OVF,
    output logic                          oTX,
    output logic                          oBUSY,
    output logic                          oFULL,
    output logic                          oEMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   oLEVEL,
    output logic                          oOVERFLOW
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txStateT;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [LVL_W-1:0] count;
    logic [LVL_W-1:0] countNext;
    logic [7:0]       headData;
    logic             pushOk;
    logic             pop;

    // Full check uses the pre-pop flag, so a write while full is dropped even
    // when the transmitter pops in the same cycle.
    assign pushOk   = iWR && !oFULL;
    assign headData = mem[rdPtr];
    assign oLEVEL   = count;

    always_comb begin
        countNext = count;
        unique case ({pushOk, pop})
            2'b10:   countNext = count + LVL_W'(1);
            2'b01:   countNext = count - LVL_W'(1);
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= iDATA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            oFULL  <= 1'b0;
            oEMPTY <= 1'b1;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count  <= countNext;
            oFULL  <= (countNext == LVL_FULL);
            oEMPTY <= (countNext == '0);
        end
    end

    // Set has priority over clear when both happen in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oOVERFLOW <= 1'b0;
        end else if (iWR && oFULL) begin
            oOVERFLOW <= 1'b1;
        end else if (iCLR_OVF) begin
            oOVERFLOW <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    txStateT           state;
    txStateT           stateNext;
    logic [BAUD_W-1:0] baudCnt;
    logic [BAUD_W-1:0] baudNext;
    logic [2:0]        bitIdx;
    logic [2:0]        bitNext;
    logic [7:0]        shiftReg;
    logic [7:0]        shiftNext;
    logic              txLevel;
    logic              baudLast;

    assign baudLast = (baudCnt == BAUD_LAST);

    always_comb begin
        stateNext = state;
        baudNext  = baudLast ? '0 : baudCnt + BAUD_W'(1);
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        pop       = 1'b0;
        txLevel   = 1'b1;

        unique case (state)
            IDLE: begin
                txLevel  = 1'b1;
                baudNext = '0;
                if (!oEMPTY) begin
                    pop       = 1'b1;
                    shiftNext = headData;
                    bitNext   = '0;
                    stateNext = START;
                end
            end
            START: begin
                txLevel = 1'b0;
                if (baudLast) begin
                    bitNext   = '0;
                    stateNext = DATA;
                end
            end
            DATA: begin
                txLevel = shiftReg[0];
                if (baudLast) begin
                    shiftNext = {1'b0, shiftReg[7:1]};
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                    end else begin
                        bitNext = bitIdx + 3'd1;
                    end
                end
            end
            STOP: begin
                txLevel = 1'b1;
                if (baudLast) begin
                    // Chain straight into the next start bit when data waits.
                    if (!oEMPTY) begin
                        pop       = 1'b1;
                        shiftNext = headData;
                        bitNext   = '0;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                baudNext  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
        end
    end

    // Line and busy are registered from the current state, so both trail the
    // state register by one cycle and stay aligned with each other.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oTX   <= 1'b1;
            oBUSY <= 1'b0;
        end else begin
            oTX   <= txLevel;
            oBUSY <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
module tb_uart_tx_stream;

    localparam int CPB = 16;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] iDATA    = '0;
    logic       iWR      = 1'b0;
    logic       iCLR_OVF = 1'b0;
    logic       oTX;
    logic       oBUSY;
    logic       oFULL;
    logic       oEMPTY;
    logic [4:0] oLEVEL;
    logic       oOVERFLOW;

    int nCmp = 0;
    int nErr = 0;

    logic [7:0] sbq [$];

    uart_tx_stream #(
        .CLK_FREQ  (160),
        .BAUD      (10),
        .FIFO_DEPTH(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .iDATA    (iDATA),
        .iWR      (iWR),
        .iCLR_OVF (iCLR_OVF),
        .oTX      (oTX),
        .oBUSY    (oBUSY),
        .oFULL    (oFULL),
        .oEMPTY   (oEMPTY),
        .oLEVEL   (oLEVEL),
        .oOVERFLOW(oOVERFLOW)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeByte(input logic [7:0] d, input bit expectSent);
        iWR   = 1'b1;
        iDATA = d;
        if (expectSent) sbq.push_back(d);
        tick();
        iWR = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((sbq.size() != 0 || oBUSY) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_time", 32'(n < budget), 32'd1);
        repeat (3) tick();
    endtask

    // Line monitor: decodes frames by sampling mid-bit and compares each
    // decoded byte against the head of the expected queue.
    int         mCnt    = 0;
    bit         mBusy   = 1'b0;
    bit         pendGap = 1'b0;
    logic [7:0] mShift  = '0;
    logic [7:0] mExp;

    always @(negedge clk) begin
        if (!reset) begin
            mBusy   = 1'b0;
            pendGap = 1'b0;
        end else begin
            if (pendGap) begin
                check("b2b_gap", 32'(oTX), 32'd0);
                pendGap = 1'b0;
            end
            if (!mBusy) begin
                if (oTX === 1'b0) begin
                    mBusy = 1'b1;
                    mCnt  = 0;
                end
            end else begin
                mCnt++;
            end
            if (mBusy) begin
                if (mCnt == CPB / 2) begin
                    check("start_bit", 32'(oTX), 32'd0);
                end else if (mCnt >= 24 && mCnt <= 136 && (mCnt % CPB) == 8) begin
                    mShift = {oTX, mShift[7:1]};
                end else if (mCnt == 152) begin
                    check("stop_mid", 32'(oTX), 32'd1);
                end else if (mCnt == 10 * CPB - 1) begin
                    check("stop_end", 32'(oTX), 32'd1);
                    mBusy = 1'b0;
                    if (sbq.size() == 0) begin
                        nCmp++;
                        nErr++;
                        $display("FAIL unexpected_frame: got 0x%0h expected no frame at %0t", mShift, $time);
                    end else begin
                        mExp = sbq.pop_front();
                        check("rx_byte", 32'(mShift), 32'(mExp));
                        pendGap = (sbq.size() > 0);
                    end
                end
            end
        end
    end

    initial begin
        bit ok;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(oTX), 32'd1);
        check("rst_busy", 32'(oBUSY), 32'd0);
        check("rst_empty", 32'(oEMPTY), 32'd1);
        check("rst_full", 32'(oFULL), 32'd0);
        check("rst_level", 32'(oLEVEL), 32'd0);
        check("rst_ovf", 32'(oOVERFLOW), 32'd0);
        reset = 1'b1;
        repeat (3) tick();

        // Single byte 0x55: write at edge N, pop at N+1, line low after N+2
        writeByte(8'h55, 1'b1);
        check("wr_level", 32'(oLEVEL), 32'd1);
        check("wr_empty", 32'(oEMPTY), 32'd0);
        tick();
        check("pop_level", 32'(oLEVEL), 32'd0);
        check("tx_high_n1", 32'(oTX), 32'd1);
        check("busy_low_n1", 32'(oBUSY), 32'd0);
        tick();
        check("tx_low_n2", 32'(oTX), 32'd0);
        check("busy_high_n2", 32'(oBUSY), 32'd1);
        waitDrain(400);
        check("single_busy_done", 32'(oBUSY), 32'd0);
        check("single_tx_idle", 32'(oTX), 32'd1);

        // Back-to-back frames
        writeByte(8'hA3, 1'b1);
        writeByte(8'h0F, 1'b1);
        waitDrain(600);

        // Overflow: 20 consecutive writes, first starts the line, 16 queue, 3 drop
        for (int i = 0; i < 20; i++) begin
            writeByte(8'(8'h30 + i), (i < 17));
        end
        check("ovf_full", 32'(oFULL), 32'd1);
        check("ovf_level", 32'(oLEVEL), 32'd16);
        check("ovf_flag", 32'(oOVERFLOW), 32'd1);
        // Dropped write and clear in the same cycle: set wins
        iWR      = 1'b1;
        iDATA    = 8'hEE;
        iCLR_OVF = 1'b1;
        tick();
        iWR      = 1'b0;
        iCLR_OVF = 1'b0;
        check("ovf_set_wins", 32'(oOVERFLOW), 32'd1);
        check("ovf_level_hold", 32'(oLEVEL), 32'd16);
        iCLR_OVF = 1'b1;
        tick();
        iCLR_OVF = 1'b0;
        check("ovf_cleared", 32'(oOVERFLOW), 32'd0);
        waitDrain(17 * 10 * CPB + 200);
        check("ovf_drained_empty", 32'(oEMPTY), 32'd1);

        // Mid-frame reset during bit 4 of 0x00 with 3 bytes queued
        writeByte(8'h00, 1'b1);
        writeByte(8'hA1, 1'b1);
        writeByte(8'hA2, 1'b1);
        writeByte(8'hA3, 1'b1);
        check("mrst_level", 32'(oLEVEL), 32'd3);
        check("mrst_tx_low", 32'(oTX), 32'd0);
        repeat (83) tick();
        #2;
        sbq.delete();
        reset = 1'b0;
        #1;
        check("mrst_tx", 32'(oTX), 32'd1);
        check("mrst_level0", 32'(oLEVEL), 32'd0);
        check("mrst_empty", 32'(oEMPTY), 32'd1);
        check("mrst_busy", 32'(oBUSY), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        ok = 1'b1;
        repeat (400) begin
            tick();
            if (oTX !== 1'b1 || oBUSY !== 1'b0) ok = 1'b0;
        end
        check("mrst_no_restart", 32'(ok), 32'd1);

        // Push and pop in the same cycle at level 5
        writeByte(8'h5A, 1'b1);
        writeByte(8'hB1, 1'b1);
        writeByte(8'hB2, 1'b1);
        writeByte(8'hB3, 1'b1);
        writeByte(8'hB4, 1'b1);
        writeByte(8'hB5, 1'b1);
        check("pp_level_pre", 32'(oLEVEL), 32'd5);
        repeat (155) tick();
        check("pp_level_before_pop", 32'(oLEVEL), 32'd5);
        writeByte(8'h11, 1'b1);
        check("pp_level_same", 32'(oLEVEL), 32'd5);
        waitDrain(7 * 10 * CPB + 200);

        check("sb_leftover", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
